// File: rtl/mux_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | mux_ctrl_pkg : shared constants and FSM encodings for the mux arbiter    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package mux_ctrl_pkg;
   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;
endpackage

`default_nettype wire

// File: rtl/mux8x1_rr_arbiter_pick.sv
// +--------------------------------------------------------------------------+
// | rr_pick8 : rotating priority encoder, first request at or after start    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_pick8
   import mux_ctrl_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] start,
   output logic             found,
   output logic [SEL_W-1:0] idx
);
   logic [SEL_W-1:0] pos;

   // Scan from the farthest offset down so the nearest request wins last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         pos = start + 3'(k);
         if (req[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
      end
   end
endmodule

`default_nettype wire

// File: rtl/mux8x1bh.sv
// +--------------------------------------------------------------------------+
// | mux8x1bh : behavioral 8:1 single-bit multiplexer                         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mux8x1bh (
   input  logic [7:0] d_i,
   input  logic [2:0] s_i,
   output logic       y_o
);
   assign y_o = d_i[s_i];
endmodule

`default_nettype wire

// File: rtl/mux8x1_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | mux8x1_rr_arbiter : round-robin, burst-limited owner of a shared 8:1 mux |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mux8x1_rr_arbiter
   import mux_ctrl_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] din,
   output logic [SEL_W-1:0] sel,
   output logic [N_REQ-1:0] gnt,
   output logic             gnt_valid,
   output logic             dout
);
   localparam logic [3:0] C_LAST = 4'(MAX_BURST - 1);

   logic [0:0]       state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             gv_q, gv_d;

   logic             release_w;
   logic [SEL_W-1:0] start_w;
   logic             found_w;
   logic [SEL_W-1:0] idx_w;
   logic             mux_w;

   assign release_w = (state_q == ST_GRANT) && (!req[sel_q] || (cnt_q == C_LAST));
   // On release the search restarts just past the outgoing owner in the same edge.
   assign start_w   = release_w ? (sel_q + 3'd1) : ptr_q;

   rr_pick8 u_pick (
      .req   (req),
      .start (start_w),
      .found (found_w),
      .idx   (idx_w)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      gv_d    = gv_q;
      if (state_q == ST_IDLE || release_w) begin
         if (release_w)
            ptr_d = sel_q + 3'd1;
         if (found_w) begin
            state_d = ST_GRANT;
            sel_d   = idx_w;
            gnt_d   = 8'(1) << idx_w;
            cnt_d   = '0;
            gv_d    = 1'b1;
         end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            gv_d    = 1'b0;
         end
      end else begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         sel_q   <= '0;
         gnt_q   <= '0;
         gv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         gv_q    <= gv_d;
      end
   end

   mux8x1bh u_mux (
      .d_i (din),
      .s_i (sel_q),
      .y_o (mux_w)
   );

   assign sel       = sel_q;
   assign gnt       = gnt_q;
   assign gnt_valid = gv_q;
   assign dout      = mux_w & gv_q;
endmodule

`default_nettype wire
